// File: rtl/slot_mapper_top.sv
// Slot mapper: expands a base slot into K consecutive tagged entries, then
// scatters the entry indices into a per-slot owner map. Optional hit mask via SLOT_MAPPER_HIT_MASK_EN.
module slot_mapper_top #(
  parameter int SIZE = 16,
  parameter int K    = 4
) (
  input  logic                                       clk,
  input  logic                                       rst_n,
  input  logic                                       in_valid,
  input  logic [$clog2(SIZE)-1:0]                    num_in,
  output logic                                       out_valid,
  output logic [$clog2(SIZE)*K-1:0]                  num_out,
  output logic [($clog2(SIZE)+$clog2(K))*K-1:0]      out,
  output logic [SIZE*$clog2(K)-1:0]                  results
`ifdef SLOT_MAPPER_HIT_MASK_EN
  ,
  output logic [SIZE-1:0]                            hit_mask
`endif
);

  localparam int NB  = $clog2(SIZE);
  localparam int BIT = $clog2(K);
  localparam int W   = NB + BIT;

  logic [NB*K-1:0]     w_num;
  logic [W*K-1:0]      w_tag;
  logic [SIZE*BIT-1:0] w_res;
  logic [SIZE-1:0]     w_hit;

  logic [NB*K-1:0]     r_num_out;
  logic [W*K-1:0]      r_out;
  logic [SIZE*BIT-1:0] r_results;
  logic [SIZE-1:0]     r_hit;
  logic                r_v1;
  logic                r_v2;

  // Generator and concat: NB-bit addition wraps modulo SIZE by truncation.
  always_comb begin
    w_num = '0;
    w_tag = '0;
    for (int unsigned k = 0; k < K; k++) begin
      w_num[k*NB +: NB] = num_in + NB'(k);
      w_tag[k*W +: W]   = {BIT'(k), w_num[k*NB +: NB]};
    end
  end

  // Selector walks entries from highest to lowest index so the lowest k wins a shared slot.
  always_comb begin
    w_res = '0;
    w_hit = '0;
    for (int unsigned i = 0; i < K; i++) begin
      int unsigned kk;
      int unsigned p;
      kk = K - 1 - i;
      p  = 32'(r_num_out[kk*NB +: NB]);
      w_res[p*BIT +: BIT] = BIT'(kk);
      w_hit[p]            = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_num_out <= '0;
      r_out     <= '0;
      r_results <= '0;
      r_hit     <= '0;
      r_v1      <= 1'b0;
      r_v2      <= 1'b0;
    end else begin
      r_v1 <= in_valid;
      r_v2 <= r_v1;
      if (in_valid) begin
        r_num_out <= w_num;
        r_out     <= w_tag;
      end
      if (r_v1) begin
        r_results <= w_res;
        r_hit     <= w_hit;
      end
    end
  end

  assign out_valid = r_v2;
  assign num_out   = r_num_out;
  assign out       = r_out;
  assign results   = r_results;

`ifdef SLOT_MAPPER_HIT_MASK_EN
  assign hit_mask = r_hit;
`else
  logic w_hit_unused;
  assign w_hit_unused = ^r_hit;
`endif

endmodule

// File: tb/tb_slot_mapper_top.sv
// Self-checking bench for slot_mapper_top: directed steps plus random traffic
// against an arithmetic reference model (SLOT_MAPPER_HIT_MASK_EN optional).
module tb_slot_mapper_top;

  localparam int SIZE = 16;
  localparam int K    = 4;
  localparam int NB   = $clog2(SIZE);
  localparam int BIT  = $clog2(K);
  localparam int W    = NB + BIT;

  logic                clk;
  logic                rst_n;
  logic                in_valid;
  logic [NB-1:0]       num_in;
  logic                out_valid;
  logic [NB*K-1:0]     num_out;
  logic [W*K-1:0]      out;
  logic [SIZE*BIT-1:0] results;
`ifdef SLOT_MAPPER_HIT_MASK_EN
  logic [SIZE-1:0]     hit_mask;
`endif

  int vectors;
  int miscompares;

  // Reference state: base number held in each stage and whether it was ever loaded.
  int m_base1, m_base2;
  bit m_has1, m_has2, m_v1, m_v2;

  slot_mapper_top #(.SIZE(SIZE), .K(K)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .num_in    (num_in),
    .out_valid (out_valid),
    .num_out   (num_out),
    .out       (out),
    .results   (results)
`ifdef SLOT_MAPPER_HIT_MASK_EN
    ,
    .hit_mask  (hit_mask)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [NB*K-1:0] m_num(int b, bit has);
    logic [NB*K-1:0] r;
    r = '0;
    if (has)
      for (int k = 0; k < K; k++) r[k*NB +: NB] = NB'((b + k) % SIZE);
    return r;
  endfunction

  function automatic logic [W*K-1:0] m_out(int b, bit has);
    logic [W*K-1:0] r;
    r = '0;
    if (has)
      for (int k = 0; k < K; k++) r[k*W +: W] = W'(k * SIZE + (b + k) % SIZE);
    return r;
  endfunction

  function automatic logic [SIZE*BIT-1:0] m_res(int b, bit has);
    logic [SIZE*BIT-1:0] r;
    int d;
    r = '0;
    if (has)
      for (int p = 0; p < SIZE; p++) begin
        d = (p - b + SIZE) % SIZE;
        if (d < K) r[p*BIT +: BIT] = BIT'(d);
      end
    return r;
  endfunction

  function automatic logic [SIZE-1:0] m_hit(int b, bit has);
    logic [SIZE-1:0] r;
    r = '0;
    if (has)
      for (int p = 0; p < SIZE; p++) r[p] = ((p - b + SIZE) % SIZE) < K;
    return r;
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_all(input string where);
    chk({where, " out_valid"}, 64'(out_valid), 64'(m_v2));
    chk({where, " num_out"},   64'(num_out),   64'(m_num(m_base1, m_has1)));
    chk({where, " out"},       64'(out),       64'(m_out(m_base1, m_has1)));
    chk({where, " results"},   64'(results),   64'(m_res(m_base2, m_has2)));
`ifdef SLOT_MAPPER_HIT_MASK_EN
    chk({where, " hit_mask"},  64'(hit_mask),  64'(m_hit(m_base2, m_has2)));
`endif
  endtask

  task automatic model_reset();
    m_base1 = 0; m_base2 = 0;
    m_has1 = 0; m_has2 = 0; m_v1 = 0; m_v2 = 0;
  endtask

  // Drive one cycle from a negedge, advance the model at the posedge, check at the next negedge.
  task automatic cycle(input bit v, input int n, input string where);
    in_valid = v;
    num_in   = NB'(n);
    @(posedge clk);
    m_v2 = m_v1;
    if (m_v1) begin m_base2 = m_base1; m_has2 = 1; end
    if (v) begin m_base1 = n % SIZE; m_has1 = 1; end
    m_v1 = v;
    @(negedge clk);
    check_all(where);
  endtask

  initial begin
    vectors = 0;
    miscompares = 0;
    model_reset();
    rst_n = 1'b0;
    in_valid = 1'b0;
    num_in = '0;
    repeat (2) @(negedge clk);
    check_all("reset");
    rst_n = 1'b1;

    // Wrap-around example with spec constants.
    cycle(1, 14, "wrap_s1");
    chk("wrap num_out const", 64'(num_out), 64'h10FE);
    chk("wrap out const",     64'(out),     64'hC607CE);
    cycle(0, 0, "wrap_s2");
    chk("wrap out_valid const", 64'(out_valid), 64'd1);
    chk("wrap results const",   64'(results),   64'h4000_000E);
`ifdef SLOT_MAPPER_HIT_MASK_EN
    chk("wrap hit_mask const",  64'(hit_mask),  64'hC003);
`endif
    cycle(0, 0, "wrap_s3");

    cycle(1, 0, "zero_s1");
    cycle(0, 0, "zero_s2");
    chk("zero results const", 64'(results), 64'hE4);
    cycle(0, 0, "zero_s3");

    // Back-to-back inputs then a 5-cycle idle hold.
    cycle(1, 5, "b2b_5");
    cycle(1, 6, "b2b_6");
    cycle(1, 7, "b2b_7");
    for (int i = 0; i < 5; i++) cycle(0, 9, "idle");

    // Reset pulse one cycle after an accepted input.
    cycle(1, 3, "rst_in");
    #1 rst_n = 1'b0;
    model_reset();
    #1 check_all("rst_async");
    #4 rst_n = 1'b1;
    @(negedge clk);
    check_all("rst_after");
    for (int i = 0; i < 4; i++) cycle(0, 0, "rst_quiet");
    cycle(1, 11, "post_rst_s1");
    cycle(0, 0, "post_rst_s2");
    cycle(0, 0, "post_rst_s3");

    for (int i = 0; i < 200; i++)
      cycle(bit'($urandom_range(0, 2) != 0), int'($urandom_range(0, SIZE - 1)), "rand");

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
